// File: rtl/alu_share_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : alu_share_arbiter
//  Description : Round-robin arbiter and sequencer that lets two requesters
//                share one combinational ALU. One request is granted per
//                cycle. The winner's operands and control drive the ALU, and
//                the ALU result and zero flag are captured into a one-entry
//                response register.
//
//  Ports
//    clk                    rising-edge clock
//    reset                  synchronous, active-high reset
//    req0_* / req1_*        requester handshakes
//                           (valid/ready, operands a/b, 2-bit op)
//    alu_in_1/alu_in_2      operands to the external ALU
//    alu_ctrl               control code to the external ALU
//                           (00 add, 01 sub, 10 and, 11 or)
//    alu_out/alu_zero       result and zero flag from the external ALU
//    rsp_valid/rsp_ready    response handshake
//    rsp_id                 requester that owns the held response
//    rsp_data/rsp_zero      captured ALU result and zero flag
//
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_share_arbiter #(
    parameter int N = 16
) (
    input  logic         clk,
    input  logic         reset,

    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [N-1:0] req0_a,
    input  logic [N-1:0] req0_b,
    input  logic [1:0]   req0_op,

    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [N-1:0] req1_a,
    input  logic [N-1:0] req1_b,
    input  logic [1:0]   req1_op,

    output logic [N-1:0] alu_in_1,
    output logic [N-1:0] alu_in_2,
    output logic [1:0]   alu_ctrl,
    input  logic [N-1:0] alu_out,
    input  logic         alu_zero,

    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic         rsp_id,
    output logic [N-1:0] rsp_data,
    output logic         rsp_zero
);

    // Response register occupancy.
    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t       r_state;
    logic         r_prio;       // requester favoured when both are valid
    logic         r_rsp_id;
    logic [N-1:0] r_rsp_data;
    logic         r_rsp_zero;

    logic         w_req_any;
    logic         w_grant_id;
    logic         w_can_accept;
    logic         w_accept;

    // ------------------------------------------------------------------------
    // Grant selection. With a single valid requester the grant follows it.
    // With both valid, the priority pointer decides. With none valid,
    // w_grant_id is a don't-care masked by w_req_any.
    // ------------------------------------------------------------------------
    always_comb begin
        w_req_any = req0_valid | req1_valid;
        if (req0_valid && req1_valid) begin
            w_grant_id = r_prio;
        end else begin
            w_grant_id = req1_valid;
        end
    end

    // A new result can be taken when the register is empty or is being
    // drained in this same cycle (pass-through drain and refill).
    assign w_can_accept = (r_state == ST_EMPTY) || rsp_ready;

    // Readies are held low while reset is asserted.
    assign w_accept   = !reset && w_can_accept && w_req_any;
    assign req0_ready = w_accept && !w_grant_id;
    assign req1_ready = w_accept &&  w_grant_id;

    // ------------------------------------------------------------------------
    // ALU drive. The winner's operands are presented even while the response
    // register is blocked, so the ALU output is already settled when the
    // register frees up. An idle ALU sees all-zero inputs.
    // ------------------------------------------------------------------------
    always_comb begin
        alu_in_1 = '0;
        alu_in_2 = '0;
        alu_ctrl = 2'b00;
        if (w_req_any) begin
            if (w_grant_id) begin
                alu_in_1 = req1_a;
                alu_in_2 = req1_b;
                alu_ctrl = req1_op;
            end else begin
                alu_in_1 = req0_a;
                alu_in_2 = req0_b;
                alu_ctrl = req0_op;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Response register, occupancy state and round-robin pointer.
    // The pointer only moves on an accepted transaction. A requester that
    // loses arbitration therefore wins the next accepted slot.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_EMPTY;
            r_prio     <= 1'b0;
            r_rsp_id   <= 1'b0;
            r_rsp_data <= '0;
            r_rsp_zero <= 1'b0;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_accept) begin
                        r_state <= ST_FULL;
                    end
                end
                ST_FULL: begin
                    // Drain with refill stays FULL. Drain alone empties.
                    // Without rsp_ready the register holds.
                    if (!w_accept && rsp_ready) begin
                        r_state <= ST_EMPTY;
                    end
                end
                default: begin
                    r_state <= ST_EMPTY;
                end
            endcase

            if (w_accept) begin
                r_rsp_data <= alu_out;
                r_rsp_zero <= alu_zero;
                r_rsp_id   <= w_grant_id;
                r_prio     <= ~w_grant_id;
            end
        end
    end

    // All response outputs come straight from flops. There is no
    // combinational path from rsp_ready to them.
    assign rsp_valid = (r_state == ST_FULL);
    assign rsp_id    = r_rsp_id;
    assign rsp_data  = r_rsp_data;
    assign rsp_zero  = r_rsp_zero;

endmodule
`default_nettype wire

// File: tb/tb_alu_share_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_share_arbiter
//  Description : Self-checking bench for alu_share_arbiter. It models the
//                external ALU and keeps a transaction-level reference model
//                of the expected grant and response behaviour.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_share_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [15:0] req0_a, req0_b, req1_a, req1_b;
    logic [1:0]  req0_op, req1_op;
    logic [15:0] alu_in_1, alu_in_2, alu_out;
    logic [1:0]  alu_ctrl;
    logic        alu_zero;
    logic        rsp_valid, rsp_ready, rsp_id, rsp_zero;
    logic [15:0] rsp_data;
    logic [15:0] w_alu_diff;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    logic        m_valid = 1'b0;
    logic        m_id    = 1'b0;
    logic [15:0] m_data  = '0;
    logic        m_zero  = 1'b0;
    logic        m_prio  = 1'b0;
    logic        g_acc0  = 1'b0;
    logic        g_acc1  = 1'b0;
    logic        g_r0    = 1'b0;
    logic        g_r1    = 1'b0;

    always #5 clk = ~clk;

    alu_share_arbiter #(.N(16)) u_dut (
        .clk        (clk),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_op    (req0_op),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_op    (req1_op),
        .alu_in_1   (alu_in_1),
        .alu_in_2   (alu_in_2),
        .alu_ctrl   (alu_ctrl),
        .alu_out    (alu_out),
        .alu_zero   (alu_zero),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_data   (rsp_data),
        .rsp_zero   (rsp_zero)
    );

    // External ALU model
    assign w_alu_diff = alu_in_1 - alu_in_2;
    assign alu_zero   = (w_alu_diff == 16'h0000);
    always_comb begin
        alu_out = '0;
        case (alu_ctrl)
            2'b00:   alu_out = alu_in_1 + alu_in_2;
            2'b01:   alu_out = alu_in_1 - alu_in_2;
            2'b10:   alu_out = alu_in_1 & alu_in_2;
            default: alu_out = alu_in_1 | alu_in_2;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] ref_result(input logic [1:0] op, input logic [15:0] a,
                                                input logic [15:0] b);
        int unsigned s;
        case (op)
            2'b00:   s = (int'(a) + int'(b)) % 65536;
            2'b01:   s = (int'(a) - int'(b) + 65536) % 65536;
            2'b10:   s = a & b;
            default: s = a | b;
        endcase
        return 16'(s);
    endfunction

    // One clock cycle: inputs are already driven. Check the combinational
    // outputs against the model, advance the model over the edge, then check
    // the registered outputs.
    task automatic cycle();
        logic       has_w, w, acc;
        logic [15:0] ea, eb;
        logic [1:0]  eo;
        #1;
        has_w = req0_valid || req1_valid;
        if (req0_valid && req1_valid) w = m_prio;
        else                          w = req1_valid;
        acc = !reset && has_w && (!m_valid || rsp_ready);
        ea  = !has_w ? 16'h0 : (w ? req1_a  : req0_a);
        eb  = !has_w ? 16'h0 : (w ? req1_b  : req0_b);
        eo  = !has_w ? 2'b00 : (w ? req1_op : req0_op);
        chk("req0_ready", {31'b0, req0_ready}, {31'b0, acc && !w});
        chk("req1_ready", {31'b0, req1_ready}, {31'b0, acc && w});
        chk("alu_in_1", {16'b0, alu_in_1}, {16'b0, ea});
        chk("alu_in_2", {16'b0, alu_in_2}, {16'b0, eb});
        chk("alu_ctrl", {30'b0, alu_ctrl}, {30'b0, eo});
        g_r0   = req0_ready;
        g_r1   = req1_ready;
        g_acc0 = acc && !w;
        g_acc1 = acc && w;
        if (reset) begin
            m_valid = 1'b0; m_id = 1'b0; m_data = '0; m_zero = 1'b0; m_prio = 1'b0;
        end else if (acc) begin
            m_valid = 1'b1;
            m_id    = w;
            m_data  = ref_result(eo, ea, eb);
            m_zero  = (ref_result(2'b01, ea, eb) == 16'h0);
            m_prio  = !w;
        end else if (rsp_ready) begin
            m_valid = 1'b0;
        end
        @(posedge clk);
        #1;
        chk("rsp_valid", {31'b0, rsp_valid}, {31'b0, m_valid});
        if (m_valid) begin
            chk("rsp_id",   {31'b0, rsp_id},   {31'b0, m_id});
            chk("rsp_data", {16'b0, rsp_data}, {16'b0, m_data});
            chk("rsp_zero", {31'b0, rsp_zero}, {31'b0, m_zero});
        end
    endtask

    task automatic drive(input logic v0, input logic [1:0] o0, input logic [15:0] a0,
                         input logic [15:0] b0, input logic v1, input logic [1:0] o1,
                         input logic [15:0] a1, input logic [15:0] b1);
        req0_valid = v0; req0_op = o0; req0_a = a0; req0_b = b0;
        req1_valid = v1; req1_op = o1; req1_a = a1; req1_b = b1;
    endtask

    initial begin
        reset = 1'b1;
        rsp_ready = 1'b0;
        drive(1'b0, 2'b00, 16'h0, 16'h0, 1'b0, 2'b00, 16'h0, 16'h0);

        // Reset state
        @(negedge clk); cycle();
        @(negedge clk); cycle();
        chk("reset_valid", {31'b0, rsp_valid}, 32'd0);
        chk("reset_id",    {31'b0, rsp_id},    32'd0);
        chk("reset_data",  {16'b0, rsp_data},  32'd0);
        chk("reset_zero",  {31'b0, rsp_zero},  32'd0);

        // Single add from req0
        @(negedge clk);
        reset = 1'b0; rsp_ready = 1'b1;
        drive(1'b1, 2'b00, 16'h0003, 16'h0004, 1'b0, 2'b00, 16'h0, 16'h0);
        cycle();
        chk("add_ready", {31'b0, g_r0}, 32'd1);
        chk("add_data",  {16'b0, rsp_data}, 32'h0007);
        chk("add_id",    {31'b0, rsp_id},   32'd0);
        chk("add_zero",  {31'b0, rsp_zero}, 32'd0);

        // Round-robin from a fresh reset
        @(negedge clk);
        reset = 1'b1;
        drive(1'b0, 2'b00, 16'h0, 16'h0, 1'b0, 2'b00, 16'h0, 16'h0);
        cycle();
        @(negedge clk);
        reset = 1'b0;
        drive(1'b1, 2'b00, 16'h0011, 16'h0022, 1'b1, 2'b11, 16'h0F00, 16'h00F0);
        cycle();
        chk("rr_grant0", {31'b0, g_r1}, 32'd0);
        chk("rr_id0", {31'b0, rsp_id}, 32'd0);
        for (int i = 1; i < 4; i++) begin
            @(negedge clk);
            cycle();
            chk("rr_grant", {31'b0, g_r1}, 32'(i % 2));
            chk("rr_id", {31'b0, rsp_id}, 32'(i % 2));
        end

        // Back-pressure: fill with 0x1234, then hold rsp_ready low
        @(negedge clk);
        drive(1'b1, 2'b00, 16'h1200, 16'h0034, 1'b0, 2'b00, 16'h0, 16'h0);
        cycle();
        chk("bp_fill", {16'b0, rsp_data}, 32'h1234);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            rsp_ready = 1'b0;
            drive(1'b0, 2'b00, 16'h0, 16'h0, 1'b1, 2'b01, 16'h0010, 16'h0010);
            cycle();
            chk("bp_ready1", {31'b0, g_r1}, 32'd0);
            chk("bp_hold", {16'b0, rsp_data}, 32'h1234);
        end
        @(negedge clk);
        rsp_ready = 1'b1;
        cycle();
        chk("bp_accept", {31'b0, g_r1}, 32'd1);
        chk("bp_data", {16'b0, rsp_data}, 32'h0000);
        chk("bp_id", {31'b0, rsp_id}, 32'd1);
        chk("bp_zero", {31'b0, rsp_zero}, 32'd1);

        // Zero flag and wrap-around
        @(negedge clk);
        drive(1'b1, 2'b10, 16'h00F0, 16'h00F0, 1'b0, 2'b00, 16'h0, 16'h0);
        cycle();
        chk("and_data", {16'b0, rsp_data}, 32'h00F0);
        chk("and_zero", {31'b0, rsp_zero}, 32'd1);
        @(negedge clk);
        drive(1'b0, 2'b00, 16'h0, 16'h0, 1'b1, 2'b01, 16'h0000, 16'h0001);
        cycle();
        chk("wrap_data", {16'b0, rsp_data}, 32'hFFFF);
        chk("wrap_zero", {31'b0, rsp_zero}, 32'd0);

        // Reset while FULL under back-pressure with both requesters valid
        @(negedge clk);
        rsp_ready = 1'b0;
        reset = 1'b1;
        drive(1'b1, 2'b00, 16'h0001, 16'h0001, 1'b1, 2'b00, 16'h0002, 16'h0002);
        cycle();
        chk("mid_rst_valid", {31'b0, rsp_valid}, 32'd0);
        chk("mid_rst_r0", {31'b0, g_r0}, 32'd0);
        chk("mid_rst_r1", {31'b0, g_r1}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        rsp_ready = 1'b1;
        cycle();
        chk("post_rst_win", {31'b0, g_r0}, 32'd1);
        chk("post_rst_id", {31'b0, rsp_id}, 32'd0);

        // Randomised traffic
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            reset     = ($urandom_range(0, 59) == 0);
            rsp_ready = ($urandom_range(0, 3) != 0);
            if (!(req0_valid && !g_acc0)) begin
                req0_valid = ($urandom_range(0, 2) != 0);
                req0_op    = 2'($urandom_range(0, 3));
                req0_a     = 16'($urandom);
                req0_b     = ($urandom_range(0, 3) == 0) ? req0_a : 16'($urandom);
            end
            if (!(req1_valid && !g_acc1)) begin
                req1_valid = ($urandom_range(0, 2) != 0);
                req1_op    = 2'($urandom_range(0, 3));
                req1_a     = 16'($urandom);
                req1_b     = ($urandom_range(0, 3) == 0) ? req1_a : 16'($urandom);
            end
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_share_arbiter.md
# alu_share_arbiter

Round-robin arbiter and sequencer that shares one combinational 16-bit ALU (ops: 00 add, 01 sub, 10 AND, 11 OR; zero flag = (in_1 − in_2) == 0) between two requesters. It grants one request per cycle, drives the ALU operands and control from the winner, and captures the ALU result and zero flag into a one-entry response register. It sits between the ALU and two clients, for example the main execute path and an address or branch helper unit.

## Interface
- N, 16, datapath width (must match the ALU)
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- req0_valid / req1_valid  in  1  request present
- req0_ready / req1_ready  out  1  request accepted this cycle
- req0_a / req1_a  in  N  operand 1
- req0_b / req1_b  in  N  operand 2
- req0_op / req1_op  in  2  ALU control code
- alu_in_1  out  N  to ALU operand 1
- alu_in_2  out  N  to ALU operand 2
- alu_ctrl  out  2  to ALU control
- alu_out  in  N  ALU result
- alu_zero  in  1  ALU zero flag
- rsp_valid  out  1  response register holds a result
- rsp_ready  in  1  consumer takes the response
- rsp_id  out  1  requester that owns the response (0/1)
- rsp_data  out  N  captured result
- rsp_zero  out  1  captured zero flag

## Operation
- Response register FSM has two states.
  - EMPTY: rsp_valid=0.
  - FULL: rsp_valid=1.
  - EMPTY→FULL on accept.
  - FULL→EMPTY on rsp_ready with no accept.
  - FULL→FULL on rsp_ready plus a new accept in the same cycle (pass-through drain and refill), or when rsp_ready=0.
- can_accept = !rsp_valid || rsp_ready.
- Grant (combinational):
  - Only one requester valid: that requester wins.
  - Both valid: the requester named by priority pointer `prio` wins.
  - Neither valid: no grant.
- reqX_ready = can_accept && grant==X. At most one ready is high per cycle.
- ALU drive (combinational):
  - Grant present: alu_in_1/alu_in_2/alu_ctrl = winner's a/b/op, regardless of can_accept.
  - No grant: drive 0/0/2'b00.
- On accept (reqX_valid && reqX_ready), at the clock edge:
  - rsp_data←alu_out, rsp_zero←alu_zero, rsp_id←X.
  - prio←~X, so the other requester is favoured next.
- prio changes only on accept. A waiting requester therefore waits at most one accepted transaction.
- Response outputs hold stable while rsp_valid=1 && rsp_ready=0.
- Arithmetic is the ALU's modulo 2^N. The block does no width extension and no carry or overflow reporting.
- Requesters hold a/b/op stable while valid and not ready. Behaviour is undefined if they drop valid before acceptance.

## Timing
- Reset values: rsp_valid=0, rsp_id=0, rsp_data=0, rsp_zero=0, prio=0 (req0 favoured).
- During reset, the ready outputs are forced 0.
- Latency: a request accepted at edge k gives rsp_valid=1 with data after edge k.
- Throughput: one op per cycle while rsp_ready=1.
- Simultaneous events:
  - rsp_ready and a new accept in the same cycle: the old response is consumed and the new one is loaded at the same edge.
  - Both valid: exactly one is accepted per cycle.
- Reset mid-operation (FULL with back-pressure): the pending response is discarded and the block returns to EMPTY with prio=0 on the next edge.
- No combinational path from rsp_ready to rsp_* outputs. Ready outputs depend combinationally on valids, prio, rsp_valid and rsp_ready.

## Test plan
- Reset, then req0 add 0x0003+0x0004 with rsp_ready=1:
  - req0_ready=1 in the same cycle.
  - Next cycle: rsp_valid=1, rsp_id=0, rsp_data=0x0007, rsp_zero=0.
- Both requesters held valid for 4 cycles, rsp_ready=1:
  - Grants go 0,1,0,1.
  - rsp_id sequence lags grants by one cycle.
- Back-pressure:
  - Setup: rsp FULL with 0x1234, rsp_ready=0 for 3 cycles, req1 valid.
  - During the 3 cycles: both readies stay 0 and rsp_* is unchanged.
  - On rsp_ready=1, req1 is accepted that cycle.
  - Next cycle holds req1's result.
- Zero and wrap:
  - req0 AND 0x00F0,0x00F0 → rsp_data=0x00F0, rsp_zero=1.
  - req1 sub 0x0000−0x0001 → rsp_data=0xFFFF, rsp_zero=0.
- Reset mid-operation:
  - Stimulus: assert reset while FULL with rsp_ready=0 and both valid.
  - Next cycle: rsp_valid=0, readies 0.
  - After release with both valid: req0 wins first.
